// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: register offsets,
// CTRL bit positions and the active-high hex glyph table {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [31:0] SEG7_VALUE_OFS = 32'h0000_0000;
  localparam logic [31:0] SEG7_CTRL_OFS  = 32'h0000_0004;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_LZ_BIT = 1;
  localparam int CTRL_DP_LSB = 4;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment glyph {g,f,e,d,c,b,a}.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7_TABLE[hex_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped 4-digit 7-segment scan controller (VALUE at BASE_ADDR, CTRL at +4).
// Optional leading-zero blanking is compiled in with LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 100000,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0014
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] Read_data,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned    DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [15:0]      value_q;
  logic             en_q;
  logic [3:0]       dp_q;
  logic             lz;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       digit;
  logic [6:0]       glyph;
  logic             blank;
  logic [7:0]       ctrl_rd;
  logic             hit_value, hit_ctrl;
  logic             unused_wdata;

  assign hit_value    = (Address == BASE_ADDR + SEG7_VALUE_OFS);
  assign hit_ctrl     = (Address == BASE_ADDR + SEG7_CTRL_OFS);
  assign unused_wdata = ^{Write_data[31:16], Write_data[3:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      en_q    <= 1'b0;
      dp_q    <= '0;
    end else begin
      if (MemWrite && hit_value) value_q <= Write_data[15:0];
      if (MemWrite && hit_ctrl) begin
        en_q <= Write_data[CTRL_EN_BIT];
        dp_q <= Write_data[CTRL_DP_LSB +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    lz_q <= 1'b0;
    else if (MemWrite && hit_ctrl) lz_q <= Write_data[CTRL_LZ_BIT];
  end
  assign lz = lz_q;
`else
  assign lz = 1'b0;
`endif

  assign ctrl_rd = {dp_q, 2'b00, lz, en_q};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (hit_value)     Read_data = {16'h0000, value_q};
      else if (hit_ctrl) Read_data = {24'h00_0000, ctrl_rd};
    end
  end

  // Disabling parks the scan at digit 0 so re-enabling starts a full first slot.
  always_comb begin
    div_d = '0;
    idx_d = '0;
    if (en_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
      end
    end
  end

  assign digit = value_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i (digit),
    .seg_o (glyph)
  );

  // A digit is blanked only when it and every more-significant digit are zero.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd3:    blank = (value_q[15:12] == 4'h0);
      2'd2:    blank = (value_q[15:8]  == 8'h00);
      2'd1:    blank = (value_q[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
    blank = blank & lz;
  end

  always_comb begin
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (en_q && !blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = {~dp_q[idx_q], ~glyph};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= 4'hF;
      seg_q <= 8'hFF;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
